// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, data word, and the
// memory arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DXFER = 2'd1,
        IXFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter. The master modport is the
// arbiter itself; the slave modport is the surrounding caches and RAM.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Memory-side arbiter: grants the single RAM port to the icache or dcache one
// word at a time. Dcache has priority, two-word dcache blocks are kept atomic
// via dlock, and starve_cnt forces an icache grant after STARVE_MAX blocks.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus,
    output logic          err,
    output word_t         err_addr
);

    arb_state_t  state, nxt;
    logic        dlock;
    logic [2:0]  starve_cnt;
    logic [7:0]  to_cnt;
    logic        dreq;
    logic        fault;
    logic        done;

    assign dreq  = bus.dREN | bus.dWEN;
    // A faulted access still completes so the cache is never left hanging.
    assign fault = (bus.ramstate == ERROR) || (to_cnt == 8'(TIMEOUT));

    // Next-state arbitration, RAM strobes and cache completion signalling.
    always_comb begin
        nxt          = state;
        done         = 1'b0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IDLE: begin
                if (dlock && dreq)
                    nxt = DXFER;
                else if (bus.iREN && starve_cnt == 3'(STARVE_MAX))
                    nxt = IXFER;
                else if (dreq)
                    nxt = DXFER;
                else if (bus.iREN)
                    nxt = IXFER;
            end
            DXFER: begin
                if (!dreq) begin
                    nxt = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (bus.ramstate == ACCESS || fault) begin
                        done      = 1'b1;
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                        nxt       = IDLE;
                    end
                end
            end
            IXFER: begin
                if (!bus.iREN) begin
                    nxt = IDLE;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (bus.ramstate == ACCESS || fault) begin
                        done      = 1'b1;
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        nxt       = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // FSM state, block lock, starvation and timeout counters, sticky error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            dlock      <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
        end else begin
            state <= nxt;

            // Cleared while idle so every transfer starts counting from zero.
            if (state == IDLE)
                to_cnt <= '0;
            else if (bus.ramstate != ACCESS)
                to_cnt <= to_cnt + 8'd1;

            if (done && fault) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= bus.ramaddr;
            end

            // Word 0 of a block locks the port for word 1.
            if (state == DXFER && done)
                dlock <= ~bus.daddr[2];
            else if (state != IDLE && nxt == IDLE && !dreq)
                dlock <= 1'b0;

            if (state == IXFER && done)
                starve_cnt <= '0;
            else if (state == IDLE && !bus.iREN)
                starve_cnt <= '0;
            else if (state == DXFER && done && bus.daddr[2] && bus.iREN &&
                     starve_cnt != 3'(STARVE_MAX))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

endmodule
